// File: rtl/spi_peripheral_fifo.sv
// -----------------------------------------------------------------------------
// spi_peripheral_fifo
//
// SPI peripheral for the OCR front end. Receives FRAME_BITS-wide frames from
// the host on COPI in any of the four SPI modes and queues them in a
// first-word-fall-through RX FIFO. At the same time it returns tx_data to the
// host on CIPO. Frames that are cut short by chip select or by an inactivity
// timeout are discarded and flagged.
//
// Ports
//   clk, rst_n      system clock (>= 8x SCLK), asynchronous active-low reset
//   SCLK, COPI,     SPI pins from the host. They are asynchronous to clk and
//   spi_cs_n        are synchronised internally.
//   CIPO            data returned to the host (0 while idle)
//   rx_enable       1 = accept new frames (FIFO draining is unaffected)
//   rx_data/valid   FIFO head / FIFO not empty
//   rx_ready        pops the head when rx_valid is 1
//   tx_data/valid   next frame to return to the host
//   tx_ready        1-cycle pulse when tx_data is taken into the shifter
//   fifo_count      FIFO occupancy
//   overrun         1-cycle pulse: a complete frame was dropped (FIFO full)
//   frame_err       1-cycle pulse: CS rose mid-frame or the frame timed out
// -----------------------------------------------------------------------------
module spi_peripheral_fifo #(
    parameter int FRAME_BITS     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                SCLK,
    input  logic                                COPI,
    input  logic                                spi_cs_n,
    output logic                                CIPO,
    input  logic                                rx_enable,
    output logic [FRAME_BITS-1:0]               rx_data,
    output logic                                rx_valid,
    input  logic                                rx_ready,
    input  logic [FRAME_BITS-1:0]               tx_data,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                overrun,
    output logic                                frame_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // ------------------------------------------------------------------
    // Synchronisers and SCLK edge detection
    // ------------------------------------------------------------------
    logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic sclk_meta_d, sclk_sync_d, sclk_dly_d;
    logic copi_meta_q, copi_sync_q;
    logic copi_meta_d, copi_sync_d;
    logic cs_meta_q, cs_sync_q;
    logic cs_meta_d, cs_sync_d;

    always_comb begin
        sclk_meta_d = SCLK;
        sclk_sync_d = sclk_meta_q;
        sclk_dly_d  = sclk_sync_q;
        copi_meta_d = COPI;
        copi_sync_d = copi_meta_q;
        cs_meta_d   = spi_cs_n;
        cs_sync_d   = cs_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // SCLK starts at its idle level so no edge is seen out of reset.
            sclk_meta_q <= 1'(CPOL);
            sclk_sync_q <= 1'(CPOL);
            sclk_dly_q  <= 1'(CPOL);
            copi_meta_q <= 1'b0;
            copi_sync_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
        end else begin
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            copi_meta_q <= copi_meta_d;
            copi_sync_q <= copi_sync_d;
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
        end
    end

    logic sclk_rise, sclk_fall;
    logic lead_edge, trail_edge;
    logic sample_edge, shift_edge;

    assign sclk_rise   = sclk_sync_q & ~sclk_dly_q;
    assign sclk_fall   = ~sclk_sync_q & sclk_dly_q;
    assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

    // ------------------------------------------------------------------
    // Frame FSM, shift registers and timeout
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  sampled_q, sampled_d;
    logic                  push_q, push_d;
    logic                  frame_err_q, frame_err_d;
    logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0] rx_shift_in;
    logic [FRAME_BITS-1:0] tx_shift_adv;
    logic                  tx_load;
    logic                  tx_bit;

    assign rx_shift_in  = (MSB_FIRST != 0) ? {rx_shift_q[FRAME_BITS-2:0], copi_sync_q}
                                           : {copi_sync_q, rx_shift_q[FRAME_BITS-1:1]};
    assign tx_shift_adv = (MSB_FIRST != 0) ? {tx_shift_q[FRAME_BITS-2:0], 1'b0}
                                           : {1'b0, tx_shift_q[FRAME_BITS-1:1]};
    assign tx_bit       = (MSB_FIRST != 0) ? tx_shift_q[FRAME_BITS-1] : tx_shift_q[0];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        sampled_d   = sampled_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cs_sync_q && rx_enable) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                tx_load   = 1'b1;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                sampled_d = 1'b0;
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (cs_sync_q || !rx_enable) begin
                    // Partial frames are dropped; only a CS abort is an error,
                    // disabling reception is a deliberate host action.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    if (cs_sync_q && (bit_cnt_q != '0)) begin
                        frame_err_d = 1'b1;
                    end
                end else if ((bit_cnt_q != '0) && (to_cnt_q == TO_LAST)) begin
                    // Stalled mid-frame: restart the frame in place so the host
                    // can resynchronise without toggling CS.
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                    sampled_d   = 1'b0;
                    tx_load     = 1'b1;
                end else begin
                    if (bit_cnt_q != '0) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                    if (sample_edge) begin
                        rx_shift_d = rx_shift_in;
                        sampled_d  = 1'b1;
                        to_cnt_d   = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            push_d  = 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else if (shift_edge && sampled_q) begin
                        // A shift edge ahead of the frame's first sample edge
                        // would skip the first bit that LOAD already presented.
                        tx_shift_d = tx_shift_adv;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tx_load) begin
            tx_shift_d = tx_valid ? tx_data : '0;
        end
    end

    assign tx_ready = tx_load & tx_valid;
    assign CIPO     = (state_q == ST_IDLE) ? 1'b0 : tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            sampled_q   <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            sampled_q   <= sampled_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_shift_q <= rx_shift_d;
        tx_shift_q <= tx_shift_d;
    end

    // ------------------------------------------------------------------
    // RX FIFO (first-word-fall-through, registered head)
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [FRAME_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  overrun_q, overrun_d;
    logic                  pop;
    logic                  push_ok;

    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid & rx_ready;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rx_data_d = rx_data_q;

        // A full FIFO still takes the frame when the head leaves this cycle.
        push_ok   = push_q & ((count_q < DEPTH_C) | pop);
        overrun_d = push_q & ~push_ok;

        if (push_ok) begin
            mem_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The head register is refreshed from the slot the next read pointer
        // addresses; if that slot is being written now, bypass the new frame.
        // When the FIFO drains the head keeps its last value.
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                rx_data_d = rx_shift_q;
            end else begin
                rx_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rx_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rx_data_q <= rx_data_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rx_data    = rx_data_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule
